// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared mapper bus bundles, mode and save-state constants
package map_pkg;
  localparam int MODE_UXROM = 0;
  localparam int MODE_CNROM = 1;
  localparam int MODE_AXROM = 2;
  localparam int MODE_GXROM = 3;

  localparam logic [6:0] SST_LATCH  = 7'd0;
  localparam logic [6:0] SST_MAPIDX = 7'd127;

  typedef enum logic [1:0] {WR_IDLE, WR_ARM, WR_COMMIT} wr_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic        m2;
  } cpu_bus_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
    logic        rd;
    logic        wr;
  } ppu_bus_t;

  typedef struct packed {
    logic [7:0] map_idx;
    logic       mir_v;
    logic       chr_ram;
  } cfg_t;

  typedef struct packed {
    logic       act;
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } sst_bus_t;

  typedef struct packed {
    cpu_bus_t   cpu;
    ppu_bus_t   ppu;
    cfg_t       cfg;
    sst_bus_t   sst;
    logic [7:0] prg_do;
    logic [7:0] chr_do;
    logic [7:0] srm_do;
  } map_in_t;

  typedef struct packed {
    logic [21:0] addr;
    logic        ce;
    logic        oe;
    logic        we;
    logic [7:0]  din;
  } mem_ctrl_t;

  typedef struct packed {
    mem_ctrl_t  prg;
    mem_ctrl_t  chr;
    mem_ctrl_t  srm;
    logic       map_cpu_oe;
    logic [7:0] map_cpu_do;
    logic       map_ppu_oe;
    logic [7:0] map_ppu_do;
    logic       ciram_a10;
    logic       ciram_ce;
    logic       irq;
    logic [7:0] sst_di;
    logic       mir_4sc;
    logic       bus_cf;
    logic       mask_off;
  } map_out_t;
endpackage

// File: rtl/map_m2_wr.sv
// rtl/map_m2_wr.sv - M2 synchronizer and IDLE/ARM/COMMIT CPU write capture
module map_m2_wr
  import map_pkg::*;
#(
  parameter bit BUS_CF = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2,
  input  logic       rw,
  input  logic       addr15,
  input  logic [7:0] data,
  input  logic [7:0] prg_do,
  input  logic       hold,
  output logic       wr_stb,
  output logic [7:0] wr_dat,
  output logic       m2_sync
);
  logic       m2_meta;
  wr_state_t  state;
  logic [7:0] bus_val;

  // ROM drives the bus too during the write, so the latch sees the wired AND
  assign bus_val = BUS_CF ? (data & prg_do) : data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_meta <= 1'b0;
      m2_sync <= 1'b0;
      state   <= WR_IDLE;
      wr_stb  <= 1'b0;
      wr_dat  <= 8'h00;
    end else begin
      m2_meta <= m2;
      m2_sync <= m2_meta;
      wr_stb  <= 1'b0;
      if (hold) begin
        state <= WR_IDLE;
      end else begin
        case (state)
          WR_IDLE: if (m2_sync && !rw && addr15) begin
            state  <= WR_ARM;
            wr_dat <= bus_val;
          end
          WR_ARM: if (!m2_sync) begin
            state  <= WR_COMMIT;
            wr_stb <= 1'b1;
          end else if (rw || !addr15) begin
            state <= WR_IDLE;
          end else begin
            wr_dat <= bus_val;
          end
          default: state <= WR_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/map_latch_gen.sv
// rtl/map_latch_gen.sv - discrete-latch mapper for the UxROM/CNROM/AxROM/GxROM family
module map_latch_gen
  import map_pkg::*;
#(
  parameter int MODE     = 0,
  parameter int PRG_BITS = 4,
  parameter int CHR_BITS = 2,
  parameter int BUS_CF   = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  map_in_t  mai,
  output map_out_t mao
);
  logic                wr_stb;
  logic [7:0]          wr_dat;
  logic                m2_sync;
  logic [7:0]          latch;
  logic [PRG_BITS-1:0] ux_bank;
  logic [21:0]         prg_a;
  logic [21:0]         chr_a;
  logic                a10;
  logic                srm_sel;

  map_m2_wr #(.BUS_CF(BUS_CF != 0)) u_wr (
    .clk    (clk),
    .rst_n  (rst_n),
    .m2     (mai.cpu.m2),
    .rw     (mai.cpu.rw),
    .addr15 (mai.cpu.addr[15]),
    .data   (mai.cpu.data),
    .prg_do (mai.prg_do),
    .hold   (mai.sst.act),
    .wr_stb (wr_stb),
    .wr_dat (wr_dat),
    .m2_sync(m2_sync)
  );

  // Save-state restore takes priority over a CPU commit in the same clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch <= 8'h00;
    else if (mai.sst.act && mai.sst.we && mai.sst.addr == SST_LATCH) latch <= mai.sst.data;
    else if (wr_stb) latch <= wr_dat;
  end

  assign ux_bank = mai.cpu.addr[14] ? '1 : latch[PRG_BITS-1:0];
  assign srm_sel = (mai.cpu.addr[15:13] == 3'b011);

  always_comb begin
    prg_a = 22'(mai.cpu.addr[14:0]);
    chr_a = 22'(mai.ppu.addr[12:0]);
    a10   = mai.cfg.mir_v ? mai.ppu.addr[10] : mai.ppu.addr[11];
    case (MODE)
      MODE_UXROM: prg_a = 22'({ux_bank, mai.cpu.addr[13:0]});
      MODE_CNROM: chr_a = 22'({latch[CHR_BITS-1:0], mai.ppu.addr[12:0]});
      MODE_AXROM: begin
        prg_a = 22'({latch[PRG_BITS-1:0], mai.cpu.addr[14:0]});
        a10   = latch[4];
      end
      MODE_GXROM: begin
        prg_a = 22'({latch[5:4], mai.cpu.addr[14:0]});
        chr_a = 22'({latch[1:0], mai.ppu.addr[12:0]});
      end
      default: ;
    endcase
  end

  always_comb begin
    mao            = '0;
    mao.prg.addr   = prg_a;
    mao.prg.ce     = mai.cpu.addr[15];
    mao.prg.oe     = mai.cpu.addr[15] & mai.cpu.rw;
    mao.prg.din    = mai.cpu.data;
    mao.srm.addr   = 22'(mai.cpu.addr[12:0]);
    mao.srm.ce     = srm_sel;
    mao.srm.oe     = srm_sel & mai.cpu.rw;
    mao.srm.we     = srm_sel & ~mai.cpu.rw & m2_sync;
    mao.srm.din    = mai.cpu.data;
    mao.chr.addr   = chr_a;
    mao.chr.ce     = ~mai.ppu.addr[13];
    mao.chr.oe     = ~mai.ppu.addr[13] & mai.ppu.rd;
    mao.chr.we     = ~mai.ppu.addr[13] & mai.ppu.wr & mai.cfg.chr_ram;
    mao.chr.din    = mai.ppu.data;
    mao.map_cpu_oe = mai.cpu.rw & (mai.cpu.addr[15] | srm_sel);
    mao.map_cpu_do = mai.cpu.addr[15] ? mai.prg_do : mai.srm_do;
    mao.map_ppu_oe = ~mai.ppu.addr[13] & mai.ppu.rd;
    mao.map_ppu_do = mai.chr_do;
    mao.ciram_a10  = a10;
    mao.ciram_ce   = mai.ppu.addr[13];
    mao.bus_cf     = (BUS_CF != 0);
    if (mai.sst.addr == SST_LATCH)       mao.sst_di = latch;
    else if (mai.sst.addr == SST_MAPIDX) mao.sst_di = mai.cfg.map_idx;
    else                                 mao.sst_di = 8'hFF;
  end
endmodule

// File: tb/tb_map_latch_gen.sv
// tb/tb_map_latch_gen.sv - scoreboard bench for map_latch_gen across all four modes
module tb_map_latch_gen;
  import map_pkg::*;

  typedef struct {logic [7:0] d; logic [7:0] p;} exp_t;

  logic     clk;
  logic     rst_n;
  map_in_t  mi;
  map_out_t mo_a, mo_b, mo_c, mo_d, mo_e;
  exp_t     exp_q[$];
  int       n_pass, n_total, stb_cnt;
  int       lat_cf, lat_nc;

  map_latch_gen #(.MODE(0), .PRG_BITS(4), .CHR_BITS(2), .BUS_CF(1)) u_a (.clk(clk), .rst_n(rst_n), .mai(mi), .mao(mo_a));
  map_latch_gen #(.MODE(0), .PRG_BITS(4), .CHR_BITS(2), .BUS_CF(0)) u_b (.clk(clk), .rst_n(rst_n), .mai(mi), .mao(mo_b));
  map_latch_gen #(.MODE(1), .PRG_BITS(4), .CHR_BITS(2), .BUS_CF(0)) u_c (.clk(clk), .rst_n(rst_n), .mai(mi), .mao(mo_c));
  map_latch_gen #(.MODE(2), .PRG_BITS(3), .CHR_BITS(2), .BUS_CF(0)) u_d (.clk(clk), .rst_n(rst_n), .mai(mi), .mao(mo_d));
  map_latch_gen #(.MODE(3), .PRG_BITS(4), .CHR_BITS(2), .BUS_CF(0)) u_e (.clk(clk), .rst_n(rst_n), .mai(mi), .mao(mo_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int m0_prg(input int lat, input int a);
    int bank;
    bank = ((a / 16384) % 2 == 1) ? 15 : lat % 16;
    return bank * 16384 + a % 16384;
  endfunction

  // Monitor: every commit pulse consumes one expected write from the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && u_a.u_wr.wr_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) check("unexpected_commit", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_dat_cf", int'(u_a.u_wr.wr_dat), int'(e.d & e.p));
          check("wr_dat_nc", int'(u_b.u_wr.wr_dat), int'(e.d));
          check("stb_nc_align", int'(u_b.u_wr.wr_stb), 1);
        end
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] dv, input logic [7:0] pv);
    @(negedge clk);
    mi.cpu.addr = a; mi.cpu.data = dv; mi.cpu.rw = 1'b0; mi.prg_do = pv; mi.cpu.m2 = 1'b1;
    if (a[15]) exp_q.push_back('{d: dv, p: pv});
    repeat (4) @(negedge clk);
    mi.cpu.m2 = 1'b0;
    repeat (5) @(negedge clk);
    mi.cpu.rw = 1'b1; mi.cpu.addr = 16'h0000;
    if (a[15]) begin
      lat_cf = int'(dv & pv);
      lat_nc = int'(dv);
    end
  endtask

  task automatic map_checks();
    int a, p;
    a = 32768 + int'($urandom_range(0, 32767));
    p = int'($urandom_range(0, 8191));
    mi.cpu.addr = 16'(a); mi.ppu.addr = 14'(p);
    #1;
    check("m0cf_prg", int'(mo_a.prg.addr), m0_prg(lat_cf, a));
    check("m0nc_prg", int'(mo_b.prg.addr), m0_prg(lat_nc, a));
    check("m1_chr", int'(mo_c.chr.addr), (lat_nc % 4) * 8192 + p);
    check("m1_prg", int'(mo_c.prg.addr), a % 32768);
    check("m2_prg", int'(mo_d.prg.addr), (lat_nc % 8) * 32768 + a % 32768);
    check("m3_prg", int'(mo_e.prg.addr), ((lat_nc / 16) % 4) * 32768 + a % 32768);
    check("m3_chr", int'(mo_e.chr.addr), (lat_nc % 4) * 8192 + p);
    check("m0_sst_latch", int'(mo_a.sst_di), lat_cf);
    mi.ppu.addr = 14'h2400;
    #1;
    check("m2_a10", int'(mo_d.ciram_a10), (lat_nc / 16) % 2);
    mi.cpu.addr = 16'h0000;
  endtask

  initial begin
    logic [15:0] ra;
    int          s0;
    bit          seen;
    n_pass = 0; n_total = 0; stb_cnt = 0; lat_cf = 0; lat_nc = 0;
    mi = '0;
    mi.cpu.rw = 1'b1; mi.cfg.map_idx = 8'h5A; mi.cfg.mir_v = 1'b1;
    rst_n = 1'b0;
    // A $6000 write held through reset must not produce SRAM write enable
    mi.cpu.addr = 16'h6000; mi.cpu.rw = 1'b0; mi.cpu.m2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_latch", int'(mo_a.sst_di), 0);
    check("rst_irq", int'(mo_a.irq), 0);
    check("rst_srm_we", int'(mo_a.srm.we), 0);
    check("rst_prg_we", int'(mo_a.prg.we), 0);
    check("bus_cf_1", int'(mo_a.bus_cf), 1);
    check("bus_cf_0", int'(mo_b.bus_cf), 0);
    check("mir_4sc", int'(mo_a.mir_4sc), 0);
    mi.cpu.m2 = 1'b0; mi.cpu.rw = 1'b1; mi.cpu.addr = 16'h0000;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cpu_write(16'h8000, 8'h05, 8'hFF);
    mi.cpu.addr = 16'h8123; #1;
    check("t1_prg_8123", int'(mo_a.prg.addr), 'h14123);
    mi.cpu.addr = 16'hC000; #1;
    check("t1_prg_c000", int'(mo_a.prg.addr), 'h3C000);

    cpu_write(16'h8000, 8'h0F, 8'h05);
    check("t2_latch_cf", int'(mo_a.sst_di), 'h05);
    check("t2_latch_nc", int'(mo_b.sst_di), 'h0F);

    cpu_write(16'hFFFF, 8'h13, 8'hFF);
    mi.cpu.addr = 16'h8000; mi.ppu.addr = 14'h2000; #1;
    check("t3_prg_bank3", int'(mo_d.prg.addr), 'h18000);
    check("t3_a10_2000", int'(mo_d.ciram_a10), 1);
    mi.ppu.addr = 14'h2400; #1;
    check("t3_a10_2400", int'(mo_d.ciram_a10), 1);
    cpu_write(16'hFFFF, 8'h03, 8'hFF);
    mi.ppu.addr = 14'h2400; #1;
    check("t3_a10_clear", int'(mo_d.ciram_a10), 0);

    s0 = stb_cnt;
    cpu_write(16'h9000, 8'h01, 8'hFF);
    cpu_write(16'h9000, 8'h02, 8'hFF);
    check("t6_two_pulses", stb_cnt - s0, 2);
    check("t6_last_wins", int'(mo_b.sst_di), 2);
    s0 = stb_cnt;
    cpu_write(16'h6000, 8'h77, 8'hFF);
    check("t6_no_stb_6000", stb_cnt - s0, 0);
    check("t6_latch_kept", int'(mo_b.sst_di), 2);

    // Save-state write lands in the very clock the commit pulse is high
    seen = 1'b0;
    fork
      cpu_write(16'h8000, 8'h07, 8'hFF);
      begin
        for (int k = 0; k < 30 && !seen; k++) begin
          @(negedge clk);
          if (u_a.u_wr.wr_stb) seen = 1'b1;
        end
        if (seen) begin
          mi.sst.act = 1'b1; mi.sst.we = 1'b1; mi.sst.addr = 7'd0; mi.sst.data = 8'h21;
          @(negedge clk);
          mi.sst.act = 1'b0; mi.sst.we = 1'b0;
        end else check("t5_stb_timeout", 0, 1);
      end
    join
    lat_cf = 'h21; lat_nc = 'h21;
    check("t5_sst_wins", int'(mo_a.sst_di), 'h21);
    mi.sst.addr = 7'd5; #1;
    check("t5_sst_addr5", int'(mo_a.sst_di), 'hFF);
    mi.sst.addr = 7'd127; #1;
    check("t5_sst_mapidx", int'(mo_a.sst_di), 'h5A);
    mi.sst.addr = 7'd0;
    map_checks();

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'(16'h4020 + $urandom_range(0, 16'h3FDF));
      else ra = 16'(16'h8000 + $urandom_range(0, 16'h7FFF));
      cpu_write(ra, 8'($urandom), 8'($urandom));
      map_checks();
    end

    // Reset in the middle of an armed write discards it
    s0 = stb_cnt;
    @(negedge clk);
    mi.cpu.addr = 16'h8000; mi.cpu.data = 8'h3C; mi.cpu.rw = 1'b0; mi.prg_do = 8'hFF; mi.cpu.m2 = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    mi.cpu.m2 = 1'b0; mi.cpu.rw = 1'b1; mi.cpu.addr = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    lat_cf = 0; lat_nc = 0;
    check("t4_no_commit", stb_cnt - s0, 0);
    check("t4_latch_cleared", int'(mo_d.sst_di), 0);
    mi.cfg.mir_v = 1'b1; mi.ppu.addr = 14'h2400; #1;
    check("t4_mir_v1", int'(mo_a.ciram_a10), 1);
    mi.cfg.mir_v = 1'b0; #1;
    check("t4_mir_h", int'(mo_a.ciram_a10), 0);
    map_checks();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
